// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//   Round-robin drain of the per-execution-unit result FIFOs onto the single
//   Common Data Bus. At most one non-empty FIFO is popped per cycle; the popped
//   word arrives on that FIFO's dout one cycle later and is broadcast on the
//   CDB together with its source index. A one-entry skid register absorbs the
//   single result that can still be in flight when the CDB consumer stalls.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   src_empty  [N_SRC]        empty flag of each result FIFO (bit i = source i)
//   src_dout   [N_SRC*WIDTH]  FIFO dout buses, source i at [i*WIDTH +: WIDTH]
//   src_r_en   [N_SRC]        one-hot-or-zero pop request to the FIFOs
//   cdb_stall  1              consumer cannot accept; hold the broadcast
//   cdb_valid  1              broadcast valid
//   cdb_data   [WIDTH]        broadcast result
//   cdb_src    [SW]           source FIFO index of cdb_data
// ---------------------------------------------------------------------------
module cdb_arbiter #(
  parameter  int N_SRC = 4,
  parameter  int WIDTH = 8,
  localparam int SW    = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_SRC-1:0]       src_empty,
  input  logic [N_SRC*WIDTH-1:0] src_dout,
  output logic [N_SRC-1:0]       src_r_en,
  input  logic                   cdb_stall,
  output logic                   cdb_valid,
  output logic [WIDTH-1:0]       cdb_data,
  output logic [SW-1:0]          cdb_src
);

  // Arbitration state
  logic [SW-1:0]    rr_ptr;
  logic             inflight;
  logic [SW-1:0]    inflight_src;

  // One-entry skid buffer
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic [SW-1:0]    skid_src;

  // Combinational grant and landing-data selection
  logic             grant_ok;
  logic             grant_hit;
  logic [SW-1:0]    grant_idx;
  logic [SW-1:0]    cand_idx;
  int               cand;
  logic [WIDTH-1:0] land_data;

  // Round-robin scan starting at rr_ptr; reset masks the pop so the FIFOs,
  // which are flushed by the same reset, never see a read while clearing.
  always_comb begin
    grant_ok  = !skid_valid && !(cdb_valid && cdb_stall && inflight) && !reset;
    grant_hit = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < N_SRC; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= N_SRC) begin
        cand = cand - N_SRC;
      end else begin
        cand = cand;
      end
      cand_idx = cand[SW-1:0];
      if (grant_ok && !grant_hit && !src_empty[cand_idx]) begin
        grant_hit = 1'b1;
        grant_idx = cand_idx;
      end else begin
        grant_hit = grant_hit;
      end
    end
    if (grant_hit) begin
      src_r_en = {{(N_SRC-1){1'b0}}, 1'b1} << grant_idx;
    end else begin
      src_r_en = '0;
    end
  end

  // Select the dout slice of the FIFO popped in the previous cycle
  always_comb begin
    land_data = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (inflight_src == SW'(k)) begin
        land_data = src_dout[k*WIDTH +: WIDTH];
      end else begin
        land_data = land_data;
      end
    end
  end

  // Pointer, in-flight tracking, output register and skid register
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr       <= '0;
      inflight     <= 1'b0;
      inflight_src <= '0;
      skid_valid   <= 1'b0;
      skid_data    <= '0;
      skid_src     <= '0;
      cdb_valid    <= 1'b0;
      cdb_data     <= '0;
      cdb_src      <= '0;
    end else begin
      if (grant_hit) begin
        if (grant_idx == SW'(N_SRC - 1)) begin
          rr_ptr <= '0;
        end else begin
          rr_ptr <= grant_idx + SW'(1);
        end
        inflight     <= 1'b1;
        inflight_src <= grant_idx;
      end else begin
        inflight <= 1'b0;
      end

      if (cdb_valid && cdb_stall) begin
        // Broadcast frozen; a word landing now can only go to the skid,
        // which is guaranteed empty because no grant was allowed meanwhile.
        if (inflight) begin
          skid_valid <= 1'b1;
          skid_data  <= land_data;
          skid_src   <= inflight_src;
        end else begin
          skid_valid <= skid_valid;
        end
      end else if (skid_valid) begin
        // Skid is older than any landing word, so it goes out first
        cdb_valid  <= 1'b1;
        cdb_data   <= skid_data;
        cdb_src    <= skid_src;
        skid_valid <= inflight;
        skid_data  <= land_data;
        skid_src   <= inflight_src;
      end else if (inflight) begin
        cdb_valid <= 1'b1;
        cdb_data  <= land_data;
        cdb_src   <= inflight_src;
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
//   Self-checking bench for cdb_arbiter (N_SRC=4, WIDTH=8). The result FIFOs
//   are emulated with queues; popped words are recorded in grant order and
//   every word accepted from the CDB (valid and not stalled) must match the
//   head of that record. Directed scenarios check exact cycle timing.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] src_empty;
  logic [N*W-1:0] src_dout;
  logic [N-1:0] src_r_en;
  logic         cdb_stall;
  logic         cdb_valid;
  logic [W-1:0] cdb_data;
  logic [1:0]   cdb_src;

  typedef logic [7:0] byte_q_t[$];
  byte_q_t     fq [N];
  logic [7:0]  dout_reg [N];
  logic [9:0]  exp_q [$];

  logic [3:0]  s_r_en;
  logic [3:0]  s_empty;
  logic        s_valid;
  logic [7:0]  s_data;
  logic [1:0]  s_src;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.N_SRC(N), .WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .src_empty (src_empty),
    .src_dout  (src_dout),
    .src_r_en  (src_r_en),
    .cdb_stall (cdb_stall),
    .cdb_valid (cdb_valid),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src)
  );

  // One clock cycle: drive inputs, sample mid-cycle, then emulate the FIFOs
  task automatic drive_cycle(input logic stall, input logic rst);
    reset     = rst;
    cdb_stall = stall;
    for (int i = 0; i < N; i++) begin
      src_empty[i]        = (fq[i].size() == 0);
      src_dout[i*W +: W]  = dout_reg[i];
    end
    #4;
    s_r_en  = src_r_en;
    s_empty = src_empty;
    s_valid = cdb_valid;
    s_data  = cdb_data;
    s_src   = cdb_src;
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < N; i++) fq[i].delete();
      exp_q.delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (s_r_en[i] && !s_empty[i]) begin
          dout_reg[i] = fq[i].pop_front();
          exp_q.push_back({2'(i), dout_reg[i]});
        end
      end
    end
  endtask

  task automatic apply_reset();
    drive_cycle(1'b0, 1'b1);
    drive_cycle(1'b0, 1'b1);
  endtask

  task automatic test_reset();
    fq[1].push_back(8'd77);
    drive_cycle(1'b0, 1'b1);
    n_checks++;
    if (s_r_en !== 4'b0000) begin
      n_fail++; $display("FAIL reset_r_en: got %b want 0000", s_r_en);
    end
    drive_cycle(1'b0, 1'b1);
    n_checks++;
    if (s_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b want 0", s_valid);
    end
    n_checks++;
    if (s_data !== 8'd0 || s_src !== 2'd0) begin
      n_fail++; $display("FAIL reset_data: got %0d/%0d want 0/0", s_data, s_src);
    end
    n_checks++;
    if (s_r_en !== 4'b0000) begin
      n_fail++; $display("FAIL reset_r_en2: got %b want 0000", s_r_en);
    end
  endtask

  task automatic test_single_source();
    logic [3:0] r_exp;
    logic       v_exp;
    apply_reset();
    fq[2].push_back(8'd5); fq[2].push_back(8'd6); fq[2].push_back(8'd7);
    for (int c = 0; c < 6; c++) begin
      drive_cycle(1'b0, 1'b0);
      r_exp = (c < 3) ? 4'b0100 : 4'b0000;
      v_exp = (c >= 2 && c <= 4);
      n_checks++;
      if (s_r_en !== r_exp) begin
        n_fail++; $display("FAIL single_r_en c%0d: got %b want %b", c, s_r_en, r_exp);
      end
      n_checks++;
      if (s_valid !== v_exp) begin
        n_fail++; $display("FAIL single_valid c%0d: got %b want %b", c, s_valid, v_exp);
      end
      if (v_exp) begin
        n_checks++;
        if (s_data !== 8'(3 + c) || s_src !== 2'd2) begin
          n_fail++; $display("FAIL single_data c%0d: got %0d/%0d want %0d/2", c, s_data, s_src, 3 + c);
        end
      end
    end
  endtask

  task automatic test_all_four();
    logic [3:0] r_exp;
    logic       v_exp;
    int         k;
    apply_reset();
    for (int i = 0; i < N; i++) begin
      fq[i].push_back(8'(10 * i));
      fq[i].push_back(8'(10 * i + 1));
    end
    for (int c = 0; c < 11; c++) begin
      drive_cycle(1'b0, 1'b0);
      r_exp = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
      v_exp = (c >= 2 && c <= 9);
      n_checks++;
      if (s_r_en !== r_exp) begin
        n_fail++; $display("FAIL all4_r_en c%0d: got %b want %b", c, s_r_en, r_exp);
      end
      n_checks++;
      if (s_valid !== v_exp) begin
        n_fail++; $display("FAIL all4_valid c%0d: got %b want %b", c, s_valid, v_exp);
      end
      if (v_exp) begin
        k = c - 2;
        n_checks++;
        if (s_data !== 8'(10 * (k % 4) + k / 4) || s_src !== 2'(k % 4)) begin
          n_fail++; $display("FAIL all4_data c%0d: got %0d/%0d want %0d/%0d", c, s_data, s_src, 10 * (k % 4) + k / 4, k % 4);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] r_tab [5];
    logic       v_tab [5];
    logic [7:0] d_tab [5];
    logic [1:0] s_tab [5];
    r_tab = '{4'b1000, 4'b0001, 4'b1000, 4'b0000, 4'b0000};
    v_tab = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    d_tab = '{8'd0, 8'd0, 8'd33, 8'd40, 8'd34};
    s_tab = '{2'd0, 2'd0, 2'd3, 2'd0, 2'd3};
    apply_reset();
    fq[3].push_back(8'd33);
    for (int c = 0; c < 5; c++) begin
      drive_cycle(1'b0, 1'b0);
      if (c == 0) begin
        fq[0].push_back(8'd40);
        fq[3].push_back(8'd34);
      end
      n_checks++;
      if (s_r_en !== r_tab[c]) begin
        n_fail++; $display("FAIL wrap_r_en c%0d: got %b want %b", c, s_r_en, r_tab[c]);
      end
      n_checks++;
      if (s_valid !== v_tab[c]) begin
        n_fail++; $display("FAIL wrap_valid c%0d: got %b want %b", c, s_valid, v_tab[c]);
      end
      if (v_tab[c]) begin
        n_checks++;
        if (s_data !== d_tab[c] || s_src !== s_tab[c]) begin
          n_fail++; $display("FAIL wrap_data c%0d: got %0d/%0d want %0d/%0d", c, s_data, s_src, d_tab[c], s_tab[c]);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic       st;
    logic [7:0] acc [$];
    int         pops;
    apply_reset();
    pops = 0;
    for (int j = 0; j < 8; j++) fq[1].push_back(8'(100 + j));
    for (int c = 0; c < 30; c++) begin
      st = (c >= 4 && c <= 7);
      drive_cycle(st, 1'b0);
      if (s_r_en != 4'b0000) pops++;
      if (st) begin
        n_checks++;
        if (s_r_en !== 4'b0000) begin
          n_fail++; $display("FAIL stall_r_en c%0d: got %b want 0000", c, s_r_en);
        end
      end
      if (c >= 4 && c <= 8) begin
        n_checks++;
        if (s_valid !== 1'b1 || s_data !== 8'd102 || s_src !== 2'd1) begin
          n_fail++; $display("FAIL stall_freeze c%0d: got %b/%0d/%0d want 1/102/1", c, s_valid, s_data, s_src);
        end
      end
      if (c == 7) begin
        n_checks++;
        if (pops != 4) begin
          n_fail++; $display("FAIL stall_pops: got %0d want 4", pops);
        end
      end
      if (s_valid && !st) acc.push_back(s_data);
    end
    n_checks++;
    if (acc.size() != 8) begin
      n_fail++; $display("FAIL stall_count: got %0d want 8", acc.size());
    end else begin
      for (int j = 0; j < 8; j++) begin
        n_checks++;
        if (acc[j] !== 8'(100 + j)) begin
          n_fail++; $display("FAIL stall_order %0d: got %0d want %0d", j, acc[j], 100 + j);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] r_tab [8];
    logic       v_tab [8];
    logic [7:0] d_tab [8];
    logic [1:0] s_tab [8];
    r_tab = '{4'b0100, 4'b0000, 4'b0000, 4'b0001, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    v_tab = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    d_tab = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd8, 8'd9, 8'd0};
    s_tab = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0};
    apply_reset();
    fq[2].push_back(8'd1); fq[2].push_back(8'd2);
    for (int c = 0; c < 8; c++) begin
      drive_cycle(1'b0, (c == 1));
      if (c == 2) begin
        fq[0].push_back(8'd8);
        fq[3].push_back(8'd9);
      end
      n_checks++;
      if (s_r_en !== r_tab[c]) begin
        n_fail++; $display("FAIL rstmid_r_en c%0d: got %b want %b", c, s_r_en, r_tab[c]);
      end
      n_checks++;
      if (s_valid !== v_tab[c]) begin
        n_fail++; $display("FAIL rstmid_valid c%0d: got %b want %b", c, s_valid, v_tab[c]);
      end
      if (v_tab[c]) begin
        n_checks++;
        if (s_data !== d_tab[c] || s_src !== s_tab[c]) begin
          n_fail++; $display("FAIL rstmid_data c%0d: got %0d/%0d want %0d/%0d", c, s_data, s_src, d_tab[c], s_tab[c]);
        end
      end
    end
  endtask

  task automatic test_empty_stall();
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      drive_cycle(c[0], 1'b0);
      n_checks++;
      if (s_r_en !== 4'b0000 || s_valid !== 1'b0) begin
        n_fail++; $display("FAIL empty_stall c%0d: got r_en %b valid %b want 0000 0", c, s_r_en, s_valid);
      end
    end
  endtask

  task automatic test_random();
    logic       st;
    logic       hold;
    logic [10:0] prev;
    logic [9:0] head;
    int         ptr;
    int         g;
    int         idx;
    int         win;
    bit         found;
    bit         done;
    apply_reset();
    ptr  = 0;
    win  = 0;
    hold = 1'b0;
    prev = '0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) < 45) begin
        idx = int'($urandom_range(0, 3));
        if (fq[idx].size() < 8) fq[idx].push_back(8'($urandom));
      end
      st = ($urandom_range(0, 99) < 30);
      drive_cycle(st, 1'b0);
      if (s_r_en != 4'b0000) begin
        found = 1'b0;
        g = 0;
        for (int k = 0; k < N; k++) begin
          idx = (ptr + k) % N;
          if (!found && !s_empty[idx]) begin
            found = 1'b1;
            g = idx;
          end
        end
        n_checks++;
        if (!found || s_r_en !== (4'b0001 << g)) begin
          n_fail++; $display("FAIL rand_grant c%0d: got %b want one-hot %0d (empty %b)", c, s_r_en, g, s_empty);
        end
        if (found) ptr = (g + 1) % N;
      end
      if (hold) begin
        n_checks++;
        if ({s_valid, s_src, s_data} !== prev) begin
          n_fail++; $display("FAIL rand_freeze c%0d: got %h want %h", c, {s_valid, s_src, s_data}, prev);
        end
      end
      if (s_valid && st) begin
        if (s_r_en != 4'b0000) win++;
        n_checks++;
        if (win > 1) begin
          n_fail++; $display("FAIL rand_stall_pops c%0d: got %0d want <=1", c, win);
        end
      end else begin
        win = 0;
      end
      if (s_valid && !st) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rand_dup c%0d: got %0d/%0d want nothing", c, s_src, s_data);
        end else begin
          head = exp_q.pop_front();
          if ({s_src, s_data} !== head) begin
            n_fail++; $display("FAIL rand_data c%0d: got %0d/%0d want %0d/%0d", c, s_src, s_data, head[9:8], head[7:0]);
          end
        end
      end
      hold = s_valid && st;
      prev = {s_valid, s_src, s_data};
    end
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      drive_cycle(1'b0, 1'b0);
      if (s_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL drain_dup: got %0d/%0d want nothing", s_src, s_data);
        end else begin
          head = exp_q.pop_front();
          if ({s_src, s_data} !== head) begin
            n_fail++; $display("FAIL drain_data: got %0d/%0d want %0d/%0d", s_src, s_data, head[9:8], head[7:0]);
          end
        end
      end
      done = !s_valid && exp_q.size() == 0 &&
             fq[0].size() == 0 && fq[1].size() == 0 && fq[2].size() == 0 && fq[3].size() == 0;
    end
    n_checks++;
    if (!done) begin
      n_fail++; $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
    end
  endtask

  initial begin
    reset     = 1'b1;
    cdb_stall = 1'b0;
    src_empty = '1;
    src_dout  = '0;
    for (int i = 0; i < N; i++) dout_reg[i] = 8'd0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_source();
    test_all_four();
    test_wrap();
    test_stall();
    test_reset_mid();
    test_empty_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
